// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O port behind the data-memory decoder.
// This block provides:
//   - debounced board buttons (btnR = switch data ready, btnL = LED ready)
//   - a switch snapshot register
//   - the LED output register, loaded by a handshake
//   - a two-bit status register that software polls
// Optional build macro IO_LED_READBACK_EN: when defined, a read of addr 11
// returns the LED register. When undefined, addr 11 reads as zero.
module io_port_ctrl #(
    parameter int DB_CYCLES   = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pRead,
    input  logic        pWrite,
    input  logic [1:0]  addr,
    input  logic [11:0] writeData,
    output logic [31:0] readData,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] switch,
    output logic [11:0] led
);

    localparam int               CNT_W    = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] ADDR_STATUS = 2'b00;
    localparam logic [1:0] ADDR_SWITCH = 2'b01;
    localparam logic [1:0] ADDR_LED    = 2'b10;
    localparam logic [1:0] ADDR_RSVD   = 2'b11;

    // Bit 0 carries btnR and bit 1 carries btnL.
    // This matches the bit positions in the status register.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btnL, btnR};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   stable_q;
        logic                   stable_prev_q;
        logic                   sync_last;

        assign sync_last = sync_q[SYNC_STAGES-1];

        // Synchronize the raw button, debounce the last stage, and remember
        // the previous stable level for edge detection.
        always_ff @(posedge clk) begin
            // NOTE: every sequential block uses non-blocking assignments, so all
            // flops read the values from before the edge. A blocking assignment
            // here would collapse the synchronizer chain into a single stage.
            if (!reset) begin
                sync_q        <= '0;
                cnt_q         <= '0;
                stable_q      <= 1'b0;
                stable_prev_q <= 1'b0;
            end else begin
                sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                stable_prev_q <= stable_q;
                if (sync_last == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_q <= sync_last;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        // A press pulse lasts one cycle, on the 0->1 edge of the debounced level.
        assign press[gi] = stable_q & ~stable_prev_q;
    end

    logic [1:0]  status_q;
    logic [15:0] switch_reg;
    logic [11:0] led_q;
    logic        read_clear;
    logic        led_accept;

    // Reading the switch data consumes it.
    assign read_clear = pRead && (addr == ADDR_SWITCH);

    // An LED write is accepted only while the port reports it is ready for output.
    assign led_accept = pWrite && (addr == ADDR_LED) && status_q[1];

    // Update the status flags, the switch snapshot and the LED register.
    // When a set and a clear hit the same flag in the same cycle, the set wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            status_q   <= 2'b00;
            switch_reg <= 16'h0000;
            led_q      <= 12'h000;
        end else begin
            if (press[0]) begin
                status_q[0] <= 1'b1;
                switch_reg  <= switch;
            end else if (read_clear) begin
                status_q[0] <= 1'b0;
            end

            if (led_accept) begin
                led_q <= writeData;
            end

            if (press[1]) begin
                status_q[1] <= 1'b1;
            end else if (led_accept) begin
                status_q[1] <= 1'b0;
            end
        end
    end

    assign led = led_q;

    // Read mux: combinational on addr, and zero whenever the port is not being read.
    always_comb begin
        // NOTE: readData gets a default first, so every path through this block
        // assigns it. Without the default, synthesis would infer a latch.
        readData = 32'h0000_0000;
        if (pRead) begin
            case (addr)
                ADDR_STATUS: readData = {30'b0, status_q};
                ADDR_SWITCH: readData = {16'b0, switch_reg};
                ADDR_LED:    readData = 32'h0000_0000;
`ifdef IO_LED_READBACK_EN
                ADDR_RSVD:   readData = {20'b0, led_q};
`else
                ADDR_RSVD:   readData = 32'h0000_0000;
`endif
                default:     readData = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Testbench for io_port_ctrl, built with DB_CYCLES=4 and SYNC_STAGES=2.
// A behavioural model predicts led and readData, and they are compared every cycle.
// Directed literal checks pin down the key points of the test plan.
module tb_io_port_ctrl;

    localparam int DB = 4;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pRead;
    logic        pWrite;
    logic [1:0]  addr;
    logic [11:0] writeData;
    logic [31:0] readData;
    logic        btnL;
    logic        btnR;
    logic [15:0] switch;
    logic [11:0] led;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    io_port_ctrl #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .pRead     (pRead),
        .pWrite    (pWrite),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .btnL      (btnL),
        .btnR      (btnR),
        .switch    (switch),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, index 0 = btnR, index 1 = btnL.
    // Each button level reaches the debouncer SS cycles late.
    // The debounced level flips after DB consecutive cycles of disagreement.
    // The flag is set on the edge after the debounced level rises.
    bit   dly [2][SS];
    int   run [2];
    bit   stab [2];
    bit   rose [2];
    bit   m_st0;
    bit   m_st1;
    logic [15:0] m_sw;
    logic [11:0] m_led;
    bit   raw [2];
    bit   d;
    bit   acc;

    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < SS; s++) dly[b][s] = 1'b0;
                run[b]  = 0;
                stab[b] = 1'b0;
                rose[b] = 1'b0;
            end
            m_st0 = 1'b0;
            m_st1 = 1'b0;
            m_sw  = 16'h0;
            m_led = 12'h0;
        end else begin
            raw[0] = btnR;
            raw[1] = btnL;
            acc = pWrite && addr == 2'd2 && m_st1;
            if (rose[0]) begin
                m_st0 = 1'b1;
                m_sw  = switch;
            end else if (pRead && addr == 2'd1) begin
                m_st0 = 1'b0;
            end
            if (acc) m_led = writeData;
            if (rose[1]) m_st1 = 1'b1;
            else if (acc) m_st1 = 1'b0;
            for (int b = 0; b < 2; b++) begin
                d = dly[b][SS-1];
                for (int s = SS - 1; s > 0; s--) dly[b][s] = dly[b][s-1];
                dly[b][0] = raw[b];
                rose[b] = 1'b0;
                if (d != stab[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        stab[b] = d;
                        run[b]  = 0;
                        rose[b] = d;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
    end

    function automatic logic [31:0] model_read();
        if (!pRead) return 32'h0;
        case (addr)
            2'd0: return {30'b0, m_st1, m_st0};
            2'd1: return {16'b0, m_sw};
`ifdef IO_LED_READBACK_EN
            2'd3: return {20'b0, m_led};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Compare the DUT against the model every cycle, after the outputs settle.
    always @(posedge clk) begin
        #2;
        if (started) begin
            check("model_led", {20'b0, led}, {20'b0, m_led});
            check("model_readData", readData, model_read());
        end
    end

    // Read one register at the current negedge. pRead stays high through the
    // next rising edge, then the task returns at the following negedge.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        pRead = 1'b1;
        addr  = a;
        #1;
        check(name, readData, exp);
        @(negedge clk);
        pRead = 1'b0;
        addr  = 2'd0;
    endtask

    task automatic wr(input logic [11:0] data);
        pWrite    = 1'b1;
        addr      = 2'd2;
        writeData = data;
        @(negedge clk);
        pWrite    = 1'b0;
        addr      = 2'd0;
        writeData = 12'h0;
    endtask

    initial begin
        reset     = 1'b0;
        pRead     = 1'b0;
        pWrite    = 1'b0;
        addr      = 2'd0;
        writeData = 12'h0;
        btnL      = 1'b1;
        btnR      = 1'b1;
        switch    = 16'hFFFF;

        // Reset: held low for two cycles with both buttons high.
        @(negedge clk);
        @(negedge clk);
        started = 1'b1;
        check("reset_led", {20'b0, led}, 32'h0);
        rd(2'd0, 32'h0, "reset_status");
        reset = 1'b1;
        @(negedge clk);
        btnL = 1'b0;
        btnR = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd0, 32'h0, "post_reset_no_status");

        // Glitch: btnR is high for only 3 cycles, one short of DB.
        btnR = 1'b1;
        repeat (3) @(negedge clk);
        btnR = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd0, 32'h0, "glitch_rejected");

        // Clean press: the flag sets at the 7th edge after btnR rises.
        switch = 16'hA5C3;
        btnR   = 1'b1;
        repeat (6) @(negedge clk);
        rd(2'd0, 32'h0, "flag_not_before_7");
        rd(2'd0, 32'h1, "flag_at_7");
        rd(2'd1, 32'h0000A5C3, "switch_snapshot");
        rd(2'd0, 32'h0, "read_clears_status0");
        switch = 16'h0000;
        repeat (10) @(negedge clk);
        rd(2'd0, 32'h0, "held_single_pulse");
        rd(2'd1, 32'h0000A5C3, "switch_reg_kept");
        btnR = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd0, 32'h0, "release_no_pulse");

        // LED handshake.
        wr(12'h3F0);
        #1 check("led_write_ignored", {20'b0, led}, 32'h0);
        btnL = 1'b1;
        repeat (8) @(negedge clk);
        btnL = 1'b0;
        rd(2'd0, 32'h2, "led_ready_set");
        wr(12'h3F0);
        #1 check("led_write_accepted", {20'b0, led}, 32'h3F0);
        rd(2'd0, 32'h0, "led_ready_cleared");
        wr(12'h055);
        #1 check("led_second_write_ignored", {20'b0, led}, 32'h3F0);
        repeat (10) @(negedge clk);

        // Collision: the switch read lands in the same cycle as the btnR flag set.
        switch = 16'h1234;
        btnR   = 1'b1;
        repeat (6) @(negedge clk);
        rd(2'd1, 32'h0000A5C3, "collision_old_value");
        rd(2'd0, 32'h1, "collision_set_wins");
        rd(2'd1, 32'h00001234, "collision_new_snapshot");
        btnR = 1'b0;
        repeat (10) @(negedge clk);

        // Readback and the idle bus.
`ifdef IO_LED_READBACK_EN
        rd(2'd3, 32'h000003F0, "led_readback");
`else
        rd(2'd3, 32'h0, "led_readback_absent");
`endif
        rd(2'd2, 32'h0, "led_addr_reads_zero");
        addr = 2'd1;
        #1 check("no_pread_zero", readData, 32'h0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
